// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment patterns and scan FSM state type.
package seg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
  localparam logic [7:0] SEG_OFF = 8'h00;
  // {g,f,e,d,c,b,a} active-high, entry k = hex digit k
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-high a..g pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller with prescaler, blanking and polarity control.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int DIV            = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic [7:0]              seg_o,
  output logic [SW-1:0]           slot_o,
  output logic                    frame_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0] SEG_MASK = {8{SEG_ACTIVE_LOW}};
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0] nib_q, nib_d;
  logic dp_q, dp_d, den_q, den_d, last, frame_q, frame_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0] seg_q, seg_d;
  logic [6:0] seg_raw;

  seg_hex_decode u_dec (.nib_i(nib_d), .seg_o(seg_raw));

  // Slot data is captured at cnt==0 and bypassed through that cycle, so the
  // output stage sees the new digit even when blanking is disabled.
  always_comb begin
    cnt_cur = state_q == ST_IDLE ? '0 : cnt_q;
    last    = cnt_cur == CW'(DIV - 1);
    nib_d   = cnt_cur == '0 ? 4'(digits_i >> {slot_q, 2'b00}) : nib_q;
    dp_d    = cnt_cur == '0 ? 1'(dp_i >> slot_q) : dp_q;
    den_d   = cnt_cur == '0 ? 1'(digit_en_i >> slot_q) : den_q;
    state_d = !en ? ST_IDLE : int'(cnt_cur) < BLANK_CYC ? ST_BLANK : ST_SHOW;
    cnt_d   = (!en || last) ? '0 : cnt_cur + 1'b1;
    slot_d  = !en ? '0 : !last ? slot_q : slot_q == SW'(NUM_DIGITS - 1) ? '0 : slot_q + 1'b1;
    frame_d = en && last && slot_q == SW'(NUM_DIGITS - 1);
    sel_d   = SEL_MASK ^ ((state_d == ST_SHOW && den_d) ? NUM_DIGITS'(1) << slot_q : '0);
    seg_d   = SEG_MASK ^ (state_d == ST_SHOW ? {dp_d, seg_raw} : SEG_OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      nib_q   <= '0;
      dp_q    <= 1'b0;
      den_q   <= 1'b0;
      frame_q <= 1'b0;
      sel_q   <= SEL_MASK;
      seg_q   <= SEG_MASK ^ SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      den_q   <= den_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign sel_o   = sel_q;
  assign seg_o   = seg_q;
  assign slot_o  = slot_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl in both output polarities.
module tb_seg_scan_ctrl;
  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] seg;
    logic       frame;
    logic [1:0] slot;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [11:0] digits = 12'h321;
  logic [2:0] dp = 3'b000;
  logic [2:0] den = 3'b111;
  logic [2:0] sel_l, sel_h;
  logic [7:0] seg_l, seg_h;
  logic [1:0] slot_l, slot_h;
  logic frame_l, frame_h;
  exp_t q[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(3), .DIV(8), .BLANK_CYC(2), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits), .dp_i(dp), .digit_en_i(den),
    .sel_o(sel_l), .seg_o(seg_l), .slot_o(slot_l), .frame_o(frame_l));

  seg_scan_ctrl #(.NUM_DIGITS(3), .DIV(8), .BLANK_CYC(2), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits), .dp_i(dp), .digit_en_i(den),
    .sel_o(sel_h), .seg_o(seg_h), .slot_o(slot_h), .frame_o(frame_h));

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("sel_lo", {5'b0, sel_l}, {5'b0, e.sel});
      check("seg_lo", seg_l, e.seg);
      check("frame_lo", {7'b0, frame_l}, {7'b0, e.frame});
      check("slot_lo", {6'b0, slot_l}, {6'b0, e.slot});
      check("sel_hi", {5'b0, sel_h}, {5'b0, ~e.sel});
      check("seg_hi", seg_h, ~e.seg);
      check("frame_hi", {7'b0, frame_h}, {7'b0, e.frame});
    end
  end

  task automatic push(input logic [2:0] sel, input logic [7:0] seg, input logic fr, input logic [1:0] sl);
    exp_t e;
    e = {sel, seg, fr, sl};
    q.push_back(e);
  endtask

  task automatic step(input logic [2:0] sel, input logic [7:0] seg, input logic fr, input logic [1:0] sl);
    @(posedge clk);
    #1;
    push(sel, seg, fr, sl);
  endtask

  task automatic off_step();
    step(3'b111, 8'hFF, 1'b0, 2'd0);
  endtask

  // Slot s, prescaler counts c0..c1: 2 blank cycles then the digit, slot index advances after count 7.
  task automatic slot_steps(input int s, input int c0, input int c1, input logic on, input logic [7:0] seg);
    logic [2:0] oh;
    oh = 3'b001 << s;
    for (int c = c0; c <= c1; c++)
      step(c < 2 ? 3'b111 : on ? ~oh : 3'b111, c < 2 ? 8'hFF : seg, c == 7 && s == 2,
           c == 7 ? 2'((s + 1) % 3) : 2'(s));
  endtask

  task automatic frame(input logic [2:0] on, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    slot_steps(0, 0, 7, on[0], s0);
    slot_steps(1, 0, 7, on[1], s1);
    slot_steps(2, 0, 7, on[2], s2);
  endtask

  initial begin
    repeat (3) off_step();
    rst_n = 1'b1;
    repeat (4) off_step();
    en = 1'b1;
    frame(3'b111, 8'hF9, 8'hA4, 8'hB0);
    frame(3'b111, 8'hF9, 8'hA4, 8'hB0);
    den = 3'b101;
    frame(3'b101, 8'hF9, 8'hA4, 8'hB0);
    den = 3'b111;
    slot_steps(0, 0, 3, 1'b1, 8'hF9);
    digits = 12'h328;
    slot_steps(0, 4, 7, 1'b1, 8'hF9);
    slot_steps(1, 0, 7, 1'b1, 8'hA4);
    slot_steps(2, 0, 7, 1'b1, 8'hB0);
    dp = 3'b010;
    frame(3'b111, 8'h80, 8'h24, 8'hB0);
    dp = 3'b000;
    slot_steps(0, 0, 7, 1'b1, 8'h80);
    slot_steps(1, 0, 7, 1'b1, 8'hA4);
    slot_steps(2, 0, 3, 1'b1, 8'hB0);
    en = 1'b0;
    repeat (3) off_step();
    en = 1'b1;
    slot_steps(0, 0, 4, 1'b1, 8'h80);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push(3'b111, 8'hFF, 1'b0, 2'd0);
    repeat (2) off_step();
    rst_n = 1'b1;
    frame(3'b111, 8'h80, 8'hA4, 8'hB0);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: actual=%0d entries left required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
